// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and per-op latency lookup.
package mdu_pkg;

  localparam logic [3:0] MDU_MFHI  = 4'd0;
  localparam logic [3:0] MDU_MFLO  = 4'd1;
  localparam logic [3:0] MDU_MTHI  = 4'd2;
  localparam logic [3:0] MDU_MTLO  = 4'd3;
  localparam logic [3:0] MDU_MULT  = 4'd4;
  localparam logic [3:0] MDU_MULTU = 4'd5;
  localparam logic [3:0] MDU_DIV   = 4'd6;
  localparam logic [3:0] MDU_DIVU  = 4'd7;
  localparam logic [3:0] MDU_MADD  = 4'd8;
  localparam logic [3:0] MDU_MADDU = 4'd9;
  localparam logic [3:0] MDU_MSUB  = 4'd10;
  localparam logic [3:0] MDU_MSUBU = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PRE,
    ST_DIV_ITER,
    ST_DIV_POST
  } mdu_state_t;

  // Cycles from accept edge to commit edge; 0 for ops that never sequence.
  function automatic int unsigned mdu_latency(input logic [3:0] op,
                                              input int unsigned width,
                                              input int unsigned mul_lat);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return mul_lat;
      MDU_DIV, MDU_DIVU: return width + 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step,
// `last` flags the step that produces the final bit.
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;

  // Shift in the next dividend bit and try to subtract the divisor.
  assign trial = {r, q[WIDTH-1]} - {1'b0, d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      r   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= dividend;
      r   <= '0;
      d   <= divisor;
      cnt <= '0;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        r <= trial[WIDTH-1:0];
        q <= {q[WIDTH-2:0], 1'b1};
      end else begin
        r <= {r[WIDTH-2:0], q[WIDTH-1]};
        q <= {q[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign quotient  = q;
  assign remainder = r;
  assign last      = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding HI/LO with fixed-latency multiply,
// restoring divide and abortable sequencing. MDU_MACC_EN enables MADD/MSUB ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned PW = 2 * WIDTH;

  mdu_state_t       state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mul_sgn;
  logic             div_sgn;
  logic             q_neg;
  logic             r_neg;
  logic             div0;
`ifdef MDU_MACC_EN
  logic             acc_add;
  logic             acc_sub;
`endif

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic [PW-1:0]    ext_a;
  logic [PW-1:0]    ext_b;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    mul_res;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             div_last;

  assign accept = start && !busy && !cancel;

  // Legal sequencing ops; accumulate ops only exist in the MACC build.
  always_comb begin
    is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MACC_EN
    is_mul = is_mul || (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  end

  // One multiplier serves both signednesses: extend to 2W, keep low 2W bits.
  assign ext_a = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  always_comb begin
    mul_res = prod;
`ifdef MDU_MACC_EN
    if (acc_add)      mul_res = {hi, lo} + prod;
    else if (acc_sub) mul_res = {hi, lo} - prod;
`endif
  end

  assign a_mag = (div_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (div_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign q_fin = q_neg ? -quot : quot;
  assign r_fin = r_neg ? -rem  : rem;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (state == ST_DIV_PRE),
    .step      (state == ST_DIV_ITER),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quot),
    .remainder (rem),
    .last      (div_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mul_sgn <= 1'b0;
      div_sgn <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MDU_MACC_EN
      acc_add <= 1'b0;
      acc_sub <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && cancel) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (op == MDU_MTHI) hi <= src_a;
              if (op == MDU_MTLO) lo <= src_a;
              if (is_mul) begin
                a_q     <= src_a;
                b_q     <= src_b;
                mul_sgn <= (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
`ifdef MDU_MACC_EN
                acc_add <= (op == MDU_MADD) || (op == MDU_MADDU);
                acc_sub <= (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
                cnt     <= 4'(mdu_latency(op, WIDTH, MUL_LAT) - 1);
                state   <= ST_MUL;
                busy    <= 1'b1;
              end
              if (is_div) begin
                a_q     <= src_a;
                b_q     <= src_b;
                div_sgn <= (op == MDU_DIV);
                state   <= ST_DIV_PRE;
                busy    <= 1'b1;
              end
            end
          end
          ST_MUL: begin
            if (cnt == 4'd0) begin
              {hi, lo} <= mul_res;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_DIV_PRE: begin
            q_neg <= div_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            r_neg <= div_sgn && a_q[WIDTH-1];
            div0  <= (b_q == '0);
            state <= ST_DIV_ITER;
          end
          ST_DIV_ITER: begin
            if (div_last) state <= ST_DIV_POST;
          end
          ST_DIV_POST: begin
            // Divide-by-zero returns all-ones quotient and the raw dividend.
            if (div0) begin
              lo <= '1;
              hi <= a_q;
            end else begin
              lo <= q_fin;
              hi <= r_fin;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    result = '0;
    if (op == MDU_MFHI)      result = hi;
    else if (op == MDU_MFLO) result = lo;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed, table-driven bench for mdu_iter (32-bit/MUL_LAT=5 instance plus a
// 16-bit/MUL_LAT=1 instance); MDU_MACC_EN selects the accumulate checks.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  logic        start16 = 1'b0;
  logic [3:0]  op16 = 4'd0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cancel16 = 1'b0;
  logic        busy16;
  logic        done16;
  logic [15:0] result16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .cancel(cancel), .busy(busy), .done(done), .result(result)
  );

  mdu_iter #(.WIDTH(16), .MUL_LAT(1)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .src_a(a16),
    .src_b(b16), .cancel(cancel16), .busy(busy16), .done(done16), .result(result16)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    op = MDU_MFHI; #1; h = result;
    op = MDU_MFLO; #1; l = result;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts busy cycles after the accept edge and samples done in the first idle cycle.
  task automatic wait_idle(output int lat, output logic dn);
    lat = 0; dn = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) lat++;
      else begin
        dn = done;
        return;
      end
    end
    chk("timeout_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] h, l;
    int          lat;
    logic        dn;
    logic        seen;

    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    vecs[3]  = '{MDU_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 34};
    vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
    vecs[5]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34};
    vecs[6]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34};
    vecs[7]  = '{MDU_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5};
    vecs[8]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9]  = '{MDU_DIV,   32'd0,        32'd5,        32'd0,        32'd0,        34};
    vecs[10] = '{MDU_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 34};

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    read_hilo(h, l);
    chk("rst_hi", 64'(h), 64'd0);
    chk("rst_lo", 64'(l), 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // Table-driven ops
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(lat, dn);
      read_hilo(h, l);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_done", i), 64'(dn), 64'd1);
      chk($sformatf("v%0d_hi", i), 64'(h), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(l), 64'(vecs[i].lo));
    end

    // MTHI then MFHI next cycle; moves never raise busy
    issue(MDU_MTHI, 32'h12345678, 32'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    op = MDU_MFHI; #1;
    chk("mfhi", 64'(result), 64'h12345678);
    issue(MDU_MTLO, 32'h0BADF00D, 32'd0);
    op = MDU_MFLO; #1;
    chk("mflo", 64'(result), 64'h0BADF00D);

    // MTLO while a divide is busy is ignored
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MTLO; src_a = 32'hDEADBEEF;
    @(posedge clk); #1; start = 1'b0;
    wait_idle(lat, dn);
    read_hilo(h, l);
    chk("busy_mtlo_lo", 64'(l), 64'd14);
    chk("busy_mtlo_hi", 64'(h), 64'd2);

    // Cancel a divide in cycle 10
    issue(MDU_MTHI, 32'hAAAA0000, 32'd0);
    issue(MDU_MTLO, 32'h00005555, 32'd0);
    issue(MDU_DIV, 32'd9, 32'd2);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    chk("cancel_done", 64'(seen), 64'd0);
    read_hilo(h, l);
    chk("cancel_hi", 64'(h), 64'hAAAA0000);
    chk("cancel_lo", 64'(l), 64'h00005555);

    // Cancel on the multiply commit edge wins
    issue(MDU_MULTU, 32'd3, 32'd3);
    repeat (4) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    chk("cancel_commit_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
    chk("cancel_commit_done", 64'(seen), 64'd0);
    read_hilo(h, l);
    chk("cancel_commit_hilo", {h, l}, 64'hAAAA0000_00005555);

    // Start coincident with cancel is ignored
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; src_a = 32'd2; src_b = 32'd2; cancel = 1'b1;
    @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", 64'(busy), 64'd0);

`ifdef MDU_MACC_EN
    issue(MDU_MTHI, 32'd0, 32'd0);
    issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
    issue(MDU_MADDU, 32'd1, 32'd1);
    wait_idle(lat, dn);
    read_hilo(h, l);
    chk("maddu_lat", 64'(lat), 64'd5);
    chk("maddu_hilo", {h, l}, 64'h00000001_00000000);
    issue(MDU_MSUB, 32'd1, 32'd1);
    wait_idle(lat, dn);
    read_hilo(h, l);
    chk("msub_hilo", {h, l}, 64'h00000000_FFFFFFFF);
`else
    issue(MDU_MTHI, 32'd0, 32'd0);
    issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
    issue(MDU_MADDU, 32'd1, 32'd1);
    chk("maddu_illegal_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("maddu_illegal_done", 64'(done), 64'd0);
    read_hilo(h, l);
    chk("maddu_illegal_hilo", {h, l}, 64'h00000000_FFFFFFFF);
`endif

    // Reset asserted mid-multiply clears everything immediately
    issue(MDU_MULT, 32'd5, 32'd5);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    read_hilo(h, l);
    chk("rstmid_hilo", {h, l}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // WIDTH=16, MUL_LAT=1: single-cycle multiply, then back-to-back ops
    @(negedge clk);
    start16 = 1'b1; op16 = MDU_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(posedge clk); #1 start16 = 1'b0;
    @(negedge clk);
    chk("w16_busy_c1", 64'(busy16), 64'd1);
    @(negedge clk);
    chk("w16_busy_c2", 64'(busy16), 64'd0);
    chk("w16_done_c2", 64'(done16), 64'd1);
    op16 = MDU_MFHI; #1 chk("w16_hi", 64'(result16), 64'hFFFE);
    op16 = MDU_MFLO; #1 chk("w16_lo", 64'(result16), 64'h0001);

    @(negedge clk);
    start16 = 1'b1; op16 = MDU_MULTU; a16 = 16'd3; b16 = 16'd4;
    @(posedge clk); #1 start16 = 1'b0;
    @(posedge clk); #1;
    chk("w16_b2b_done", 64'(done16), 64'd1);
    start16 = 1'b1; op16 = MDU_MULT; a16 = 16'hFFFE; b16 = 16'd3;
    @(posedge clk); #1 start16 = 1'b0;
    chk("w16_b2b_busy", 64'(busy16), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("w16_b2b_done2", 64'(done16), 64'd1);
    op16 = MDU_MFHI; #1 chk("w16_b2b_hi", 64'(result16), 64'hFFFF);
    op16 = MDU_MFLO; #1 chk("w16_b2b_lo", 64'(result16), 64'hFFFA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multiply/divide unit for the EX stage, successor to the fixed-latency 32-bit unit. It holds HI/LO and runs signed and unsigned multiply and divide plus MTHI/MTLO/MFHI/MFLO. Multiply uses a configurable fixed latency; divide is a true radix-2 iterative datapath. A `cancel` input lets the exception/flush logic abort an in-flight operation without disturbing HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand width and HI/LO register width.
- `MUL_LAT`, 5: multiply latency in cycles; legal range 1..15.

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: issue strobe for `op`; sampled each rising edge.
- `op`  in  4: 0 MFHI, 1 MFLO, 2 MTHI, 3 MTLO, 4 MULT, 5 MULTU, 6 DIV, 7 DIVU, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU.
- `src_a`  in  WIDTH: rs operand; also the data source for MTHI/MTLO.
- `src_b`  in  WIDTH: rt operand.
- `cancel`  in  1: abort any in-flight operation.
- `busy`  out  1: an operation is in flight.
- `done`  out  1: one-cycle pulse after HI/LO commit.
- `result`  out  WIDTH: combinational read port. Gives HI when `op`=0, LO when `op`=1, otherwise 0.

## Operation
- Acceptance: a start is accepted only when `start`=1, `busy`=0 and `cancel`=0. A start while busy is ignored; the pipeline must stall on `busy`.
- MTHI/MTLO: when accepted, HI or LO is written with `src_a` at that same edge. Neither raises `busy`.
- MFHI/MFLO: pure reads with no sequencing. During `busy` they return the pre-operation HI/LO.
- FSM states are IDLE, MUL, DIV_PRE, DIV_ITER and DIV_POST.
- Multiply path: IDLE goes to MUL on an accepted op 4/5/8–11.
  - The operands are latched and the full 2·WIDTH product is formed, signed for 4/8/10 and unsigned for 5/9/11.
  - After MUL_LAT cycles: {HI,LO} is loaded with the product for 4/5, with {HI,LO}+product for 8/9, and with {HI,LO}−product for 10/11.
  - Accumulate arithmetic is modulo 2^(2·WIDTH).
- Divide path: IDLE goes to DIV_PRE on op 6/7.
  - DIV_PRE latches the operand magnitudes and the result signs.
  - DIV_ITER runs WIDTH restoring steps, one quotient bit per cycle.
  - DIV_POST applies the signs and commits LO=quotient, HI=remainder, then returns to IDLE.
  - Signed results truncate toward zero; the remainder takes the sign of the dividend.
- Divisor zero: LO is all ones and HI equals `src_a`, with the full latency still taken.
- Signed overflow (MIN / −1): LO=MIN and HI=0.
- Cancel: when `cancel`=1 in any non-IDLE state, the next edge goes to IDLE. HI/LO are unchanged and `done` stays 0.
- Cancel coincident with the commit edge: cancel wins.
- Cancel coincident with start: start is ignored.
- Reset (asynchronous, at any time, including mid-operation): HI=0, LO=0, state IDLE, counter 0, `busy`=0, `done`=0.

## Timing
- Let the accept edge be E0.
- Multiply: `busy` is high in cycles 1..MUL_LAT. HI/LO commit at edge E(MUL_LAT), where `busy` falls. `done` is high for the single following cycle.
- Divide: total latency L = WIDTH+2 (one DIV_PRE cycle, WIDTH iteration cycles, one DIV_POST cycle). `busy` is high in cycles 1..L and the commit happens at E(L). With WIDTH=32 this is 34 cycles.
- A new start may be accepted in the cycle where `done`=1, so back-to-back ops have no bubble.
- `result` is combinational from `op` and HI/LO; a commit is visible in the cycle after the commit edge.

## Configuration
- `MDU_MACC_EN` defined: ops 8–11 accumulate as described above.
- Without `MDU_MACC_EN`: ops 8–11 are treated as illegal. They are never accepted, `busy` stays 0, HI/LO are unchanged, and no accumulate adder is synthesised.

## Structure
- Shared package `mdu_pkg`:
  - op encoding constants (MDU_MFHI … MDU_MSUBU);
  - state enum `mdu_state_t`;
  - function returning the latency for an op given WIDTH and MUL_LAT.
- Sub-module `mdu_div_core`:
  - contains the WIDTH-step restoring divider (magnitude in, quotient/remainder out, `step` enable, `load`, `last` flag);
  - the top level owns the FSM, sign handling, multiply, accumulate and HI/LO.

## Test plan
- MULT with `src_a`=0xFFFFFFFE (−2), `src_b`=3 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV with −7 / 2 → after 34 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with 7 / 0 → LO=0xFFFFFFFF, HI=7. DIV with 0x80000000 / −1 → LO=0x80000000, HI=0.
- MTHI 0x12345678, then MFHI in the next cycle → `result`=0x12345678. Start DIV and issue MTLO while `busy` → MTLO is ignored and LO receives the quotient.
- Start DIV, assert `cancel` at cycle 10 → `busy` is 0 in cycle 11, HI/LO keep their prior values, `done` never pulses. Deassert `reset_n` mid-MULT → `busy`=0 and HI=LO=0 immediately.
- With `MDU_MACC_EN`: HI=0, LO=0xFFFFFFFF, then MADDU with 1×1 → HI=1, LO=0. MSUB with 1×1 → HI=0, LO=0xFFFFFFFF. Without the macro, the same MADDU leaves `busy`=0 and HI/LO unchanged.
- Parameter sweep with WIDTH=16, MUL_LAT=1: MULTU 0xFFFF×0xFFFF → HI=0xFFFE, LO=0x0001 after 1 cycle. A back-to-back MULT accepted in the `done` cycle runs with no idle bubble.
